// File: rtl/chip7458_exerciser.sv
// Exhaustive stimulus/response checker for the 7458 AND-OR chip.
// Walks all 1024 input vectors, compares the chip outputs against the
// 7458 truth function, and reports pass, a saturating error count and
// the first failing vector.
module chip7458_exerciser #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             p1a,
  output logic             p1b,
  output logic             p1c,
  output logic             p1d,
  output logic             p1e,
  output logic             p1f,
  output logic             p2a,
  output logic             p2b,
  output logic             p2c,
  output logic             p2d,
  input  logic             p1y,
  input  logic             p2y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [9:0]       first_fail_vec
);

  localparam int unsigned   VEC_W    = 10;
  localparam logic [VEC_W-1:0] VEC_LAST = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   first_q, first_d;
  logic               fail_seen_q, fail_seen_d;
  logic               pass_q, pass_d;
  logic [VEC_W-1:0]   pins_q, pins_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic e1_c, e2_c, mismatch_c;

  // Expected chip response for the vector currently on the pins.
  assign e1_c       = (&vec_q[2:0]) | (&vec_q[5:3]);
  assign e2_c       = (&vec_q[7:6]) | (&vec_q[9:8]);
  assign mismatch_c = (p1y != e1_c) | (p2y != e2_c);

  // Next-state and next-output logic; outputs are computed from the
  // next state so the registered versions line up with the state.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    err_d       = err_q;
    first_d     = first_q;
    fail_seen_d = fail_seen_q;
    pass_d      = pass_q;
    pins_d      = '0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = APPLY;
          vec_d       = '0;
          err_d       = '0;
          pass_d      = 1'b0;
          first_d     = '0;
          fail_seen_d = 1'b0;
        end
      end
      APPLY: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (mismatch_c) begin
          if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
          if (!fail_seen_q) begin
            first_d     = vec_q;
            fail_seen_d = 1'b1;
          end
        end
        if (vec_q == VEC_LAST) begin
          state_d = FINISH;
          pass_d  = ~(fail_seen_q | mismatch_c);
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          state_d = APPLY;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == APPLY) || (state_d == CHECK);
    done_d = (state_d == FINISH);
    pins_d = busy_d ? vec_d : '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      err_q       <= '0;
      first_q     <= '0;
      fail_seen_q <= 1'b0;
      pass_q      <= 1'b0;
      pins_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      first_q     <= first_d;
      fail_seen_q <= fail_seen_d;
      pass_q      <= pass_d;
      pins_q      <= pins_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign {p2d, p2c, p2b, p2a, p1f, p1e, p1d, p1c, p1b, p1a} = pins_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = first_q;

endmodule

// File: tb/tb_chip7458_exerciser.sv
// Bench for chip7458_exerciser: two instances (8- and 10-bit error
// counters) run in lockstep against a behavioural 7458 chip whose
// behaviour (golden, stuck outputs, swapped outputs, random flips) is
// selected per run.
module tb_chip7458_exerciser;

  logic clk = 1'b0;
  logic reset;
  logic start;
  int   mode;
  logic [1023:0] flip1, flip2;

  logic [9:0] pv8, pv10;
  logic       y1_8, y2_8, y1_10, y2_10;
  logic       busy_8, done_8, pass_8, busy_10, done_10, pass_10;
  logic [7:0] err_8;
  logic [9:0] err_10;
  logic [9:0] first_8, first_10;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chip7458_exerciser #(.ERR_W(8)) u8 (
    .clk(clk), .reset(reset), .start(start),
    .p1a(pv8[0]), .p1b(pv8[1]), .p1c(pv8[2]), .p1d(pv8[3]), .p1e(pv8[4]),
    .p1f(pv8[5]), .p2a(pv8[6]), .p2b(pv8[7]), .p2c(pv8[8]), .p2d(pv8[9]),
    .p1y(y1_8), .p2y(y2_8), .busy(busy_8), .done(done_8), .pass(pass_8),
    .err_count(err_8), .first_fail_vec(first_8)
  );

  chip7458_exerciser #(.ERR_W(10)) u10 (
    .clk(clk), .reset(reset), .start(start),
    .p1a(pv10[0]), .p1b(pv10[1]), .p1c(pv10[2]), .p1d(pv10[3]), .p1e(pv10[4]),
    .p1f(pv10[5]), .p2a(pv10[6]), .p2b(pv10[7]), .p2c(pv10[8]), .p2d(pv10[9]),
    .p1y(y1_10), .p2y(y2_10), .busy(busy_10), .done(done_10), .pass(pass_10),
    .err_count(err_10), .first_fail_vec(first_10)
  );

  // 7458 truth function written as plain arithmetic on the vector index.
  function automatic bit truth1(int v);
    return ((v & 7) == 7) || (((v >> 3) & 7) == 7);
  endfunction

  function automatic bit truth2(int v);
    return (((v >> 6) & 3) == 3) || (((v >> 8) & 3) == 3);
  endfunction

  // Chip under test: 0 golden, 1 p1y stuck 0, 2 p2y stuck 1,
  // 3 outputs swapped, 4 golden with random per-vector flips.
  function automatic logic [1:0] chip_out(int m, logic [9:0] pins,
                                          logic [1023:0] f1, logic [1023:0] f2);
    int  v;
    bit  t1, t2;
    v  = int'(pins);
    t1 = truth1(v);
    t2 = truth2(v);
    case (m)
      1:       return {1'b0, t2};
      2:       return {t1, 1'b1};
      3:       return {t2, t1};
      4:       return {t1 ^ f1[v], t2 ^ f2[v]};
      default: return {t1, t2};
    endcase
  endfunction

  always_comb {y1_8, y2_8}   = chip_out(mode, pv8, flip1, flip2);
  always_comb {y1_10, y2_10} = chip_out(mode, pv10, flip1, flip2);

  // Reference: count mismatching vectors and the first one.
  task automatic ref_model(input int m, output int cnt, output int first);
    logic [1:0] y;
    cnt   = 0;
    first = 0;
    for (int v = 0; v < 1024; v++) begin
      y = chip_out(m, 10'(v), flip1, flip2);
      if ((y[1] != truth1(v)) || (y[0] != truth2(v))) begin
        if (cnt == 0) first = v;
        cnt++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // One full run. Start is sampled at edge T; k counts negedges after
  // edge T+k. Busy covers k=0..2047, done is at k=2048, idle at k=2049.
  task automatic run(input string tag, input int m, input bit hold, input bit pulse,
                     input int exp_cnt, input int exp_first);
    int busy_n8, busy_n10, done_n, done_k, wait_n;
    bit exp_pass;
    exp_pass = (exp_cnt == 0);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    busy_n8 = 0; busy_n10 = 0; done_n = 0; done_k = -1;
    for (int k = 0; k <= 2050; k++) begin
      @(negedge clk);
      if (!hold) start = pulse && (k == 499);
      if (k < 2050) begin
        if (busy_8)  busy_n8++;
        if (busy_10) busy_n10++;
        if (done_8) begin done_n++; done_k = k; end
      end
      if (k == 5)    chk({tag, " pins_vec2"}, int'(pv8), 2);
      if (k == 1999) chk({tag, " pins_vec999"}, int'(pv8), 999);
      if (k == 2048) begin
        chk({tag, " pass8"},   int'(pass_8),   int'(exp_pass));
        chk({tag, " pass10"},  int'(pass_10),  int'(exp_pass));
        chk({tag, " err8"},    int'(err_8),    sat(exp_cnt, 255));
        chk({tag, " err10"},   int'(err_10),   sat(exp_cnt, 1023));
        chk({tag, " first8"},  int'(first_8),  exp_first);
        chk({tag, " first10"}, int'(first_10), exp_first);
      end
      if (k == 2049) begin
        chk({tag, " idle_busy"}, int'(busy_8), 0);
        chk({tag, " idle_pins"}, int'(pv8), 0);
      end
      if (k == 2050) begin
        if (hold) chk({tag, " restart_busy"}, int'(busy_8), 1);
        else      chk({tag, " hold_err8"}, int'(err_8), sat(exp_cnt, 255));
      end
    end
    chk({tag, " busy_cycles8"},  busy_n8, 2048);
    chk({tag, " busy_cycles10"}, busy_n10, 2048);
    chk({tag, " done_pulses"},   done_n, 1);
    chk({tag, " done_at"},       done_k, 2048);
    if (hold) begin
      start  = 1'b0;
      wait_n = 0;
      while (!done_8 && wait_n < 2100) begin
        @(negedge clk);
        wait_n++;
      end
      chk({tag, " second_run_done"}, int'(done_8), 1);
      @(negedge clk);
    end
  endtask

  typedef struct {
    string name;
    int    mode;
    int    exp_cnt;
    int    exp_first;
  } vec_t;

  vec_t tbl[4];
  int   rcnt, rfirst;

  initial begin
    // Mismatch totals: p1y=0 fails where e1=1 (15/64 of 1024 = 240);
    // p2y=1 fails where e2=0 (9/16 of 1024 = 576); swapped fails where
    // e1!=e2, i.e. 240 + 448 - 2*105 = 478.
    tbl[0] = '{"golden", 0,   0, 0};
    tbl[1] = '{"p1y0",   1, 240, 7};
    tbl[2] = '{"p2y1",   2, 576, 0};
    tbl[3] = '{"swap",   3, 478, 7};

    mode  = 0;
    flip1 = '0;
    flip2 = '0;
    start = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy",  int'(busy_8),  0);
    chk("rst done",  int'(done_8),  0);
    chk("rst pass",  int'(pass_8),  0);
    chk("rst err",   int'(err_8),   0);
    chk("rst first", int'(first_8), 0);
    chk("rst pins",  int'(pv8),     0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++)
      run(tbl[i].name, tbl[i].mode, 1'b0, 1'b0, tbl[i].exp_cnt, tbl[i].exp_first);

    // Mid-run reset aborts without a done pulse.
    @(negedge clk);
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy",  int'(busy_8),  0);
    chk("midrst pins",  int'(pv8),     0);
    chk("midrst err8",  int'(err_8),   0);
    chk("midrst err10", int'(err_10),  0);
    chk("midrst done",  int'(done_8),  0);
    begin
      int dn = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done_8) dn++;
      end
      chk("midrst no_done", dn, 0);
    end
    run("post_reset", 0, 1'b0, 1'b0, 0, 0);

    // Extra start pulse mid-run is ignored; held start gives back-to-back runs.
    run("pulse500", 0, 1'b0, 1'b1, 0, 0);
    run("held",     0, 1'b1, 1'b0, 0, 0);

    // Randomised fault patterns against the reference model.
    for (int r = 0; r < 2; r++) begin
      int dens;
      dens = (r == 0) ? 2 : 30;
      for (int v = 0; v < 1024; v++) begin
        flip1[v] = ($urandom_range(0, 99) < dens);
        flip2[v] = ($urandom_range(0, 99) < dens);
      end
      ref_model(4, rcnt, rfirst);
      run((r == 0) ? "rand_sparse" : "rand_dense", 4, 1'b0, 1'b0, rcnt, rfirst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
